// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory-side responder: bus command encoding,
// transaction tag type, per-tag slot record and default memory geometry.
package mem_responder_pkg;

    // Default geometry of the responder's backing store
    localparam int MEM_WORDS_DEFAULT   = 8192;
    localparam int MEM_LATENCY_DEFAULT = 12;

    // Countdown register width; holds latencies 1..31
    localparam int CNT_W = 5;

    // Tag space is 4 bits wide; tag 0 is reserved for "none / retry"
    localparam int NUM_TAGS = 16;

    // Encoding 2'b11 is left undefined and is treated like BUS_NONE
    typedef enum logic [1:0] {
        BUS_NONE  = 2'b00,
        BUS_LOAD  = 2'b01,
        BUS_STORE = 2'b10
    } BUS_COMMAND;

    typedef logic [3:0] MEM_TAG_t;

    // One in-flight load: busy flag, cycles left until return, captured data
    typedef struct packed {
        logic             busy;
        logic [CNT_W-1:0] countdown;
        logic [63:0]      data;
    } MEM_SLOT_t;

    // Tags rotate 1..15 and skip the reserved value 0
    function automatic MEM_TAG_t advanceTag(input MEM_TAG_t tag);
        return (tag == 4'd15) ? 4'd1 : tag + 4'd1;
    endfunction

endpackage

// File: rtl/mem_tag_tracker.sv
// Tag bookkeeping for the memory responder. Owns the fifteen in-flight
// slots, the rotating next tag and the countdown that decides when each
// load's data is handed back to the requester.
module mem_tag_tracker
    import mem_responder_pkg::*;
#(
    parameter int MEM_LATENCY = MEM_LATENCY_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_acceptAny,
    input  logic        i_acceptLoad,
    input  logic [63:0] i_loadData,
    output MEM_TAG_t    o_nextTag,
    output logic        o_nextFree,
    output MEM_TAG_t    o_retTag,
    output logic [63:0] o_retData
);

    localparam logic [CNT_W-1:0] LATENCY_CNT = CNT_W'(MEM_LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    MEM_SLOT_t        r_slots [NUM_TAGS];
    MEM_TAG_t         r_nextTag;

    MEM_TAG_t         w_retTag;
    logic [63:0]      w_retData;
    logic [CNT_W-1:0] w_matureCount;

    // Slot lifecycle: countdown of every busy slot, release on maturity,
    // tag rotation on any accept, and capture of a newly accepted load.
    // A load accepted into a slot that is maturing this very cycle wins,
    // because its assignment comes after the release in this block.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_TAGS; i++) begin
                r_slots[i] <= '0;
            end
            r_nextTag <= 4'd1;
        end else begin
            for (int i = 1; i < NUM_TAGS; i++) begin
                if (r_slots[i].busy) begin
                    if (r_slots[i].countdown == CNT_ONE) begin
                        r_slots[i].busy <= 1'b0;
                    end else begin
                        r_slots[i].countdown <= r_slots[i].countdown - CNT_ONE;
                    end
                end
            end
            if (i_acceptAny) begin
                r_nextTag <= advanceTag(r_nextTag);
            end
            if (i_acceptLoad) begin
                r_slots[r_nextTag] <= '{busy: 1'b1, countdown: LATENCY_CNT, data: i_loadData};
            end
        end
    end

    // Find the slot whose countdown has reached one; its tag and data are
    // presented for exactly this cycle and the slot frees on the next edge
    always_comb begin
        w_retTag      = '0;
        w_retData     = '0;
        w_matureCount = '0;
        for (int i = 1; i < NUM_TAGS; i++) begin
            if (r_slots[i].busy && (r_slots[i].countdown == CNT_ONE)) begin
                w_retTag      = MEM_TAG_t'(i);
                w_retData     = r_slots[i].data;
                w_matureCount = w_matureCount + CNT_ONE;
            end
        end
    end

    // A slot that returns this cycle counts as free, so a stalled requester
    // is accepted on the same cycle the blocking slot delivers its data
    assign o_nextTag  = r_nextTag;
    assign o_nextFree = !r_slots[r_nextTag].busy || (r_slots[r_nextTag].countdown == CNT_ONE);
    assign o_retTag   = w_retTag;
    assign o_retData  = w_retData;

    // Fixed latency with one accept per cycle leaves at most one slot maturing
    a_singleMature: assert property (@(posedge clock) disable iff (reset) w_matureCount <= CNT_ONE);

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the unified processor memory bus. Holds the
// backing array, decodes load/store accepts against the tag tracker and
// offers a preload port for benches and boot images.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int MEM_WORDS   = MEM_WORDS_DEFAULT,
    parameter int MEM_LATENCY = MEM_LATENCY_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  proc2mem_command,
    input  logic [63:0] proc2mem_addr,
    input  logic [63:0] proc2mem_data,
    input  logic        preload_en,
    input  logic [63:0] preload_addr,
    input  logic [63:0] preload_data,
    output logic [3:0]  mem2proc_response,
    output logic [63:0] mem2proc_data,
    output logic [3:0]  mem2proc_tag
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    logic [63:0]      r_mem [MEM_WORDS];

    logic [IDX_W-1:0] w_cmdIndex;
    logic [IDX_W-1:0] w_preIndex;
    logic [63:0]      w_loadData;
    logic             w_isLoad;
    logic             w_isStore;
    logic             w_acceptAny;
    logic             w_acceptLoad;
    logic             w_acceptStore;
    MEM_TAG_t         w_nextTag;
    logic             w_nextFree;
    MEM_TAG_t         w_retTag;
    logic [63:0]      w_retData;
    logic             w_unusedAddrBits;

    // Word index from a byte address; byte offset and high bits are dropped
    assign w_cmdIndex = proc2mem_addr[3 +: IDX_W];
    assign w_preIndex = preload_addr[3 +: IDX_W];

    assign w_unusedAddrBits = ^{proc2mem_addr[63:3+IDX_W], proc2mem_addr[2:0],
                                preload_addr[63:3+IDX_W], preload_addr[2:0]};

    // Asynchronous read so a load captures the contents before any write
    // landing on the same edge
    assign w_loadData = r_mem[w_cmdIndex];

    // Accept only when idle-free: valid command, out of reset and the slot
    // for next_tag available. There is no search for another free tag.
    assign w_isLoad      = (proc2mem_command == BUS_LOAD);
    assign w_isStore     = (proc2mem_command == BUS_STORE);
    assign w_acceptAny   = (w_isLoad || w_isStore) && !reset && w_nextFree;
    assign w_acceptLoad  = w_acceptAny && w_isLoad;
    assign w_acceptStore = w_acceptAny && w_isStore;

    // Array writes: preload first so an accepted store to the same word
    // on the same edge overrides it. Preload works even during reset and
    // the array itself is never cleared.
    always_ff @(posedge clock) begin
        if (preload_en) begin
            r_mem[w_preIndex] <= preload_data;
        end
        if (w_acceptStore) begin
            r_mem[w_cmdIndex] <= proc2mem_data;
        end
    end

    mem_tag_tracker #(
        .MEM_LATENCY (MEM_LATENCY)
    ) u_tagTracker (
        .clock        (clock),
        .reset        (reset),
        .i_acceptAny  (w_acceptAny),
        .i_acceptLoad (w_acceptLoad),
        .i_loadData   (w_loadData),
        .o_nextTag    (w_nextTag),
        .o_nextFree   (w_nextFree),
        .o_retTag     (w_retTag),
        .o_retData    (w_retData)
    );

    // Response and return outputs are forced quiet while reset is held
    assign mem2proc_response = w_acceptAny ? w_nextTag : 4'd0;
    assign mem2proc_tag      = reset ? 4'd0  : w_retTag;
    assign mem2proc_data     = reset ? 64'd0 : w_retData;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance at latency 12 for the
// functional checks and one at latency 20 for the tag-exhaustion stall.
module tb_mem_responder;
    import mem_responder_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;

    logic [1:0]  aCmd;
    logic [63:0] aAddr, aData;
    logic        aPreEn;
    logic [63:0] aPreAddr, aPreData;
    logic [3:0]  aResp, aTag;
    logic [63:0] aRetData;

    logic [1:0]  bCmd;
    logic [63:0] bAddr, bData;
    logic        bPreEn;
    logic [63:0] bPreAddr, bPreData;
    logic [3:0]  bResp, bTag;
    logic [63:0] bRetData;

    mem_responder #(.MEM_WORDS(8192), .MEM_LATENCY(12)) dut (
        .clock             (clock),
        .reset             (reset),
        .proc2mem_command  (aCmd),
        .proc2mem_addr     (aAddr),
        .proc2mem_data     (aData),
        .preload_en        (aPreEn),
        .preload_addr      (aPreAddr),
        .preload_data      (aPreData),
        .mem2proc_response (aResp),
        .mem2proc_data     (aRetData),
        .mem2proc_tag      (aTag)
    );

    mem_responder #(.MEM_WORDS(8192), .MEM_LATENCY(20)) dutSlow (
        .clock             (clock),
        .reset             (reset),
        .proc2mem_command  (bCmd),
        .proc2mem_addr     (bAddr),
        .proc2mem_data     (bData),
        .preload_en        (bPreEn),
        .preload_addr      (bPreAddr),
        .preload_data      (bPreData),
        .mem2proc_response (bResp),
        .mem2proc_data     (bRetData),
        .mem2proc_tag      (bTag)
    );

    int cycleCnt = 0;
    always @(posedge clock) cycleCnt <= cycleCnt + 1;

    // Log every returned tag with the edge count of the cycle it appears in
    int          aRetCycle[$];
    logic [3:0]  aRetTag[$];
    logic [63:0] aRetVal[$];
    int          bRetCycle[$];
    logic [3:0]  bRetTag[$];
    logic [63:0] bRetVal[$];

    always @(negedge clock) begin
        if (aTag != 4'd0) begin
            aRetCycle.push_back(cycleCnt);
            aRetTag.push_back(aTag);
            aRetVal.push_back(aRetData);
        end
        if (bTag != 4'd0) begin
            bRetCycle.push_back(cycleCnt);
            bRetTag.push_back(bTag);
            bRetVal.push_back(bRetData);
        end
    end

    int vectorCount = 0;
    int missCount   = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] cmd, input logic [63:0] addr, input logic [63:0] data);
        aCmd  = cmd;
        aAddr = addr;
        aData = data;
    endtask

    task automatic clearLogs();
        aRetCycle.delete(); aRetTag.delete(); aRetVal.delete();
        bRetCycle.delete(); bRetTag.delete(); bRetVal.delete();
    endtask

    task automatic doReset();
        reset = 1'b1;
        aCmd  = BUS_NONE;
        bCmd  = BUS_NONE;
        step();
        step();
        reset = 1'b0;
        clearLogs();
    endtask

    // Offer a command on DUT A, check the same-cycle response, then clock it
    task automatic issueA(input string name, input logic [1:0] cmd, input logic [63:0] addr,
                          input logic [63:0] data, input logic [3:0] expResp, output int acceptEdge);
        applyStimulus(cmd, addr, data);
        @(negedge clock);
        checkOutput(name, 64'(aResp), 64'(expResp));
        step();
        acceptEdge = cycleCnt;
        applyStimulus(BUS_NONE, 64'd0, 64'd0);
    endtask

    task automatic expectSingleReturn(input string name, input int expCycle, input logic [3:0] expTag,
                                      input logic [63:0] expData);
        checkOutput({name, "_count"}, 64'(aRetTag.size()), 64'd1);
        if (aRetTag.size() >= 1) begin
            checkOutput({name, "_cycle"}, 64'(aRetCycle[0]), 64'(expCycle));
            checkOutput({name, "_tag"}, 64'(aRetTag[0]), 64'(expTag));
            checkOutput({name, "_data"}, aRetVal[0], expData);
        end
        clearLogs();
    endtask

    initial begin
        int acc, acc2, lastAcc;
        int accB[16];

        reset = 1'b1;
        aCmd = BUS_NONE; aAddr = '0; aData = '0; aPreEn = 1'b0; aPreAddr = '0; aPreData = '0;
        bCmd = BUS_NONE; bAddr = '0; bData = '0; bPreEn = 1'b0; bPreAddr = '0; bPreData = '0;

        // Reset behaviour, with a preload issued while reset is held
        aPreEn = 1'b1; aPreAddr = 64'h40; aPreData = 64'hDEADBEEF_00000001;
        applyStimulus(BUS_LOAD, 64'h40, 64'd0);
        @(negedge clock);
        checkOutput("respDuringReset", 64'(aResp), 64'd0);
        step();
        aPreEn = 1'b0;
        step();
        reset = 1'b0;
        applyStimulus(BUS_NONE, 64'd0, 64'd0);
        @(negedge clock);
        checkOutput("resetTag", 64'(aTag), 64'd0);
        checkOutput("resetData", aRetData, 64'd0);
        step();
        clearLogs();

        // Basic load of preloaded word, latency 12
        issueA("loadResp", BUS_LOAD, 64'h40, 64'd0, 4'd1, acc);
        repeat (16) step();
        expectSingleReturn("loadRet", acc + 11, 4'd1, 64'hDEADBEEF_00000001);

        // Store then load: store consumes tag 1 without a return
        doReset();
        issueA("storeResp", BUS_STORE, 64'h80, 64'h1234, 4'd1, acc);
        issueA("loadAfterStoreResp", BUS_LOAD, 64'h80, 64'd0, 4'd2, acc);
        repeat (16) step();
        expectSingleReturn("storeLoad", acc + 11, 4'd2, 64'h1234);

        // Load sees old data despite a later store; a following load sees the store
        aPreEn = 1'b1; aPreAddr = 64'h80; aPreData = 64'h5;
        step();
        aPreEn = 1'b0;
        issueA("orderLoad1Resp", BUS_LOAD, 64'h80, 64'd0, 4'd3, acc);
        issueA("orderStoreResp", BUS_STORE, 64'h80, 64'h9, 4'd4, acc2);
        issueA("orderLoad2Resp", BUS_LOAD, 64'h80, 64'd0, 4'd5, acc2);
        repeat (16) step();
        checkOutput("order_count", 64'(aRetTag.size()), 64'd2);
        if (aRetTag.size() >= 2) begin
            checkOutput("order1_cycle", 64'(aRetCycle[0]), 64'(acc + 11));
            checkOutput("order1_tag", 64'(aRetTag[0]), 64'd3);
            checkOutput("order1_data", aRetVal[0], 64'h5);
            checkOutput("order2_tag", 64'(aRetTag[1]), 64'd5);
            checkOutput("order2_data", aRetVal[1], 64'h9);
        end
        clearLogs();

        // Reset three cycles after a load accept drops it silently
        doReset();
        issueA("midResetResp", BUS_LOAD, 64'h40, 64'd0, 4'd1, acc);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (20) step();
        checkOutput("droppedLoad_count", 64'(aRetTag.size()), 64'd0);
        clearLogs();
        issueA("postResetResp", BUS_LOAD, 64'h40, 64'd0, 4'd1, acc);
        repeat (16) step();
        expectSingleReturn("postReset", acc + 11, 4'd1, 64'hDEADBEEF_00000001);

        // Idle encodings, tag wrap over 16 stores, store beats same-edge preload
        doReset();
        issueA("cmd11Resp", 2'b11, 64'h100, 64'd0, 4'd0, acc);
        issueA("cmdNoneResp", BUS_NONE, 64'h100, 64'd0, 4'd0, acc);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) begin
                aPreEn = 1'b1; aPreAddr = 64'h178; aPreData = 64'hBAD;
            end
            issueA($sformatf("wrapResp%0d", i), BUS_STORE, 64'h100 + 64'(8 * i), 64'h100 + 64'(i),
                   4'((i % 15) + 1), acc);
        end
        aPreEn = 1'b0;
        issueA("wrapLoadResp", BUS_LOAD, 64'h178, 64'd0, 4'd2, acc);
        repeat (16) step();
        expectSingleReturn("storeWins", acc + 11, 4'd2, 64'h10F);

        // Tag exhaustion on the latency-20 instance
        doReset();
        for (int i = 0; i < 16; i++) begin
            bPreEn = 1'b1; bPreAddr = 64'h200 + 64'(8 * i); bPreData = 64'hA000 + 64'(i);
            step();
        end
        bPreEn = 1'b0;
        bCmd = BUS_LOAD;
        for (int i = 0; i < 15; i++) begin
            bAddr = 64'h200 + 64'(8 * i);
            @(negedge clock);
            checkOutput($sformatf("stallResp%0d", i + 1), 64'(bResp), 64'(i + 1));
            step();
            accB[i] = cycleCnt;
        end
        bAddr = 64'h278;
        while (cycleCnt < accB[0] + 19) begin
            @(negedge clock);
            checkOutput($sformatf("stallHold@%0d", cycleCnt - accB[0]), 64'(bResp), 64'd0);
            step();
        end
        @(negedge clock);
        checkOutput("stallAcceptResp", 64'(bResp), 64'd1);
        checkOutput("stallAcceptRetTag", 64'(bTag), 64'd1);
        step();
        lastAcc = cycleCnt;
        accB[15] = lastAcc;
        bCmd = BUS_NONE;
        repeat (25) step();
        checkOutput("stall_count", 64'(bRetTag.size()), 64'd16);
        if (bRetTag.size() >= 16) begin
            for (int i = 0; i < 16; i++) begin
                checkOutput($sformatf("stallRet%0d_tag", i), 64'(bRetTag[i]), 64'((i % 15) + 1));
                checkOutput($sformatf("stallRet%0d_cycle", i), 64'(bRetCycle[i]), 64'(accB[i] + 19));
                checkOutput($sformatf("stallRet%0d_data", i), bRetVal[i], 64'hA000 + 64'(i));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
